// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing helpers for the FIFO burst reader.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

    // Width of a counter that must reach cycles-1 ($clog2, floored at 1 bit).
    function automatic int unsigned to_cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/fifo_burst_out_reg.sv
// Registered valid/ready stream output stage: load a beat, hold it until consumed.
module fifo_burst_out_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rrst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_flush,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    // Flush wins over load; data is only rewritten on a load so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a commanded number of words from a show-ahead FIFO onto a valid/ready stream.
// Optional empty-FIFO timeout abort is built when FIFO_BURST_READER_TIMEOUT_EN is defined.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rrst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("fifo_burst_reader: TIMEOUT_CYCLES must be at least 2");
    end

    state_e               r_state;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic                 r_busy;
    logic                 r_done;

    logic w_m_valid;
    logic w_m_last;
    logic w_pop;
    logic w_burst_end;
    logic w_timeout;

    // Pop only when a beat is owed, a word is present and the output slot is free or draining.
    assign w_pop = (r_state == ACTIVE) && (r_remaining != '0) && !fifo_empty
                && (!w_m_valid || m_ready);

    assign w_burst_end = (r_remaining == '0)
                      && (!w_m_valid || (w_m_valid && m_ready && w_m_last));

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int unsigned TO_W = to_cnt_width(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_timeout = (r_state == ACTIVE) && (r_remaining != '0) && fifo_empty
                    && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Consecutive-empty counter; err is sticky until the next accepted start.
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_pop || (r_state != ACTIVE) || w_timeout) begin
                r_to_cnt <= '0;
            end else if ((r_remaining != '0) && fifo_empty) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Burst sequencing; done is registered on entry to DONE so it lasts exactly that one cycle.
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_remaining <= burst_len;
                        r_state     <= ACTIVE;
                        r_busy      <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (w_timeout || w_burst_end) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    fifo_burst_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rrst_n  (rrst_n),
        .i_load  (w_pop),
        .i_data  (fifo_rdata),
        .i_last  (r_remaining == LEN_WIDTH'(1)),
        .i_flush (w_timeout),
        .i_ready (m_ready),
        .o_valid (w_m_valid),
        .o_data  (m_data),
        .o_last  (w_m_last)
    );

    assign fifo_r_en = w_pop;
    assign m_valid   = w_m_valid;
    assign m_last    = w_m_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: show-ahead FIFO model, scoreboard of expected beats.
// Timeout scenario is exercised when FIFO_BURST_READER_TIMEOUT_EN is defined.
module tb_fifo_burst_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_r_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH     (DW),
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rrst_n     (rrst_n),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Show-ahead FIFO model: pushes from the stimulus, pops on fifo_r_en.
    logic [DW-1:0] fmem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = fmem[rd_ptr[5:0]];
    always @(posedge clk) if (fifo_r_en) rd_ptr <= rd_ptr + 1;

    // Downstream ready: 0 = always ready, 1 = pattern 1,0,0, 2 = manual.
    int   rdy_mode = 0;
    int   rdy_ph = 0;
    logic rdy_man = 1'b0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                m_ready = (rdy_ph == 0);
                rdy_ph  = (rdy_ph == 2) ? 0 : rdy_ph + 1;
            end
            2:       m_ready = rdy_man;
            default: m_ready = 1'b1;
        endcase
    end

    beat_t exp_q[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int viol = 0, pop_cnt = 0, beat_cnt = 0, done_cnt = 0, busy_cnt = 0, cyc = 0;
    int start_cyc = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
    bit want_first = 0, prev_stall = 0, prev_done = 0;
    beat_t held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: scoreboard beats, hold-under-stall, protocol counters.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!rrst_n) begin
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            if (fifo_r_en) pop_cnt++;
            if (fifo_r_en && fifo_empty) viol++;
            if (m_valid && !m_ready && fifo_r_en) viol++;
            if (busy) busy_cnt++;
            if (want_first && m_valid) begin
                first_cyc  = cyc;
                want_first = 0;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_beat", 32'({m_data, m_last}), 32'(held));
            end
            if (m_valid && m_ready) begin
                beat_cnt++;
                last_cyc = cyc;
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = 'x;
                chk("beat", 32'({m_data, m_last}), 32'(e));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (prev_done) viol++;
            end
            prev_done  = done;
            prev_stall = m_valid && !m_ready;
            held       = {m_data, m_last};
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fmem[wr_ptr[5:0]] = w;
        wr_ptr++;
    endtask

    task automatic expect_beat(input logic [DW-1:0] w, input logic l);
        beat_t b;
        b.d = w;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic do_start(input logic [LW-1:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start_cyc  = cyc;
        want_first = 1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit found = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                found = 1;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
        tick();
    endtask

    task automatic set_rdy_mode(input int m);
        @(negedge clk);
        rdy_mode = m;
        tick();
    endtask

    initial begin
        int p0, b0, d0, bz0;

        rrst_n = 1'b0;
        tick(3);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
        rrst_n = 1'b1;
        tick(2);

        // Back-to-back burst of 4 with ready high.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        expect_beat(8'h11, 0); expect_beat(8'h22, 0); expect_beat(8'h33, 0); expect_beat(8'h44, 1);
        p0 = pop_cnt; b0 = beat_cnt; d0 = done_cnt;
        do_start(8'd4);
        wait_done("t1_done_seen", 50);
        chk("t1_pops", 32'(pop_cnt - p0), 32'd4);
        chk("t1_beats", 32'(beat_cnt - b0), 32'd4);
        chk("t1_latency", 32'(first_cyc - start_cyc), 32'd2);
        chk("t1_back2back", 32'(last_cyc - first_cyc), 32'd3);
        chk("t1_done_after_last", 32'(done_cyc - last_cyc), 32'd1);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Backpressure pattern 1,0,0.
        set_rdy_mode(1);
        push(8'hAA); push(8'hBB); push(8'hCC);
        expect_beat(8'hAA, 0); expect_beat(8'hBB, 0); expect_beat(8'hCC, 1);
        p0 = pop_cnt; b0 = beat_cnt;
        do_start(8'd3);
        wait_done("t2_done_seen", 100);
        chk("t2_pops", 32'(pop_cnt - p0), 32'd3);
        chk("t2_beats", 32'(beat_cnt - b0), 32'd3);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        set_rdy_mode(0);

        // FIFO runs dry mid-burst, refilled later.
        push(8'h01); push(8'h02);
        expect_beat(8'h01, 0); expect_beat(8'h02, 0); expect_beat(8'h03, 0);
        expect_beat(8'h04, 0); expect_beat(8'h05, 1);
        p0 = pop_cnt; b0 = beat_cnt;
        do_start(8'd5);
        tick(10);
        push(8'h03); push(8'h04); push(8'h05);
        wait_done("t3_done_seen", 100);
        chk("t3_pops", 32'(pop_cnt - p0), 32'd5);
        chk("t3_beats", 32'(beat_cnt - b0), 32'd5);
        chk("t3_gap", 32'((last_cyc - first_cyc) >= 10), 32'd1);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length burst.
        p0 = pop_cnt; b0 = beat_cnt; bz0 = busy_cnt;
        do_start(8'd0);
        wait_done("t4_done_seen", 20);
        chk("t4_busy_cycles", 32'(busy_cnt - bz0), 32'd2);
        chk("t4_pops", 32'(pop_cnt - p0), 32'd0);
        chk("t4_beats", 32'(beat_cnt - b0), 32'd0);

        // Start during ACTIVE is ignored.
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        expect_beat(8'h21, 0); expect_beat(8'h22, 1);
        p0 = pop_cnt; d0 = done_cnt;
        do_start(8'd2);
        start = 1'b1;
        burst_len = 8'd7;
        tick();
        start = 1'b0;
        wait_done("t4b_done_seen", 50);
        chk("t4b_pops", 32'(pop_cnt - p0), 32'd2);
        chk("t4b_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
        chk("t4b_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t4b_sb_empty", 32'(exp_q.size()), 32'd0);
        expect_beat(8'h23, 0); expect_beat(8'h24, 1);
        do_start(8'd2);
        wait_done("t4c_done_seen", 50);
        chk("t4c_fifo_left", 32'(wr_ptr - rd_ptr), 32'd0);

        // Reset mid-burst after two words have left the FIFO.
        @(negedge clk);
        rdy_man  = 1'b0;
        rdy_mode = 2;
        tick();
        push(8'h61); push(8'h62); push(8'h63); push(8'h64); push(8'h65); push(8'h66);
        expect_beat(8'h61, 0);
        p0 = pop_cnt; d0 = done_cnt;
        do_start(8'd6);
        tick(4);
        @(negedge clk);
        rdy_man = 1'b1;
        @(negedge clk);
        rdy_man = 1'b0;
        tick(3);
        chk("t5_pops_before_rst", 32'(pop_cnt - p0), 32'd2);
        chk("t5_first_accepted", 32'(exp_q.size()), 32'd0);
        rrst_n = 1'b0;
        #1;
        chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_m_data", 32'(m_data), 32'd0);
        chk("t5_rst_m_last", 32'(m_last), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
        tick();
        rrst_n = 1'b1;
        tick(3);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_fifo_left", 32'(wr_ptr - rd_ptr), 32'd4);
        set_rdy_mode(0);
        expect_beat(8'h63, 0); expect_beat(8'h64, 0); expect_beat(8'h65, 0); expect_beat(8'h66, 1);
        p0 = pop_cnt;
        do_start(8'd4);
        wait_done("t5b_done_seen", 50);
        chk("t5b_pops", 32'(pop_cnt - p0), 32'd4);
        chk("t5b_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t5b_fifo_left", 32'(wr_ptr - rd_ptr), 32'd0);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        // One word for a 3-word burst: abort after 16 empty cycles.
        push(8'h7A);
        expect_beat(8'h7A, 0);
        do_start(8'd3);
        wait_done("t6_done_seen", 100);
        chk("t6_done_time", 32'(done_cyc - start_cyc), 32'd18);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        tick(5);
        chk("t6_err_sticky", 32'(err), 32'd1);
        do_start(8'd0);
        chk("t6_err_cleared", 32'(err), 32'd0);
        wait_done("t6b_done_seen", 20);
`else
        chk("err_tied_low", 32'(err), 32'd0);
`endif

        chk("protocol_viol", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
